adder4_cla_reg: RTL and testbench

//   Registered carry-lookahead adder: F = A + B + C0, carry-out on C4.

---
 rtl/adder4_cla_reg.sv | 90 +++++++++
 tb/tb_adder4_cla_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/adder4_cla_reg.sv
// Registered carry-lookahead adder built from chained 4-bit CLA groups; {C4,F} = A + B + C0.
// Define ADDER_OVF_EN to add the registered signed-overflow output OVF.
module adder4_cla_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       gg,
    output logic       pg
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Fully expanded lookahead: every carry is a two-level function of g/p/ci.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;
endmodule

module adder4_cla_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic             C4,
    output logic [WIDTH-1:0] F
`ifdef ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);
    localparam int NG = WIDTH / 4;

    logic [NG:0]      gc;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    pg;
    logic [WIDTH-1:0] sum;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("adder4_cla_reg: WIDTH must be a positive multiple of 4");
    end

    assign gc[0] = C0;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        adder4_cla_group u_grp (
            .a  (A[4*k +: 4]),
            .b  (B[4*k +: 4]),
            .ci (gc[k]),
            .s  (sum[4*k +: 4]),
            .gg (gg[k]),
            .pg (pg[k])
        );
        // Group carry-out from group generate/propagate, feeding the next group.
        assign gc[k+1] = gg[k] | (pg[k] & gc[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            F  <= '0;
            C4 <= 1'b0;
        end else begin
            F  <= sum;
            C4 <= gc[NG];
        end
    end

`ifdef ADDER_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit: c = a ^ b ^ s.
    logic c_msb;
    assign c_msb = A[WIDTH-1] ^ B[WIDTH-1] ^ sum[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) OVF <= 1'b0;
        else     OVF <= gc[NG] ^ c_msb;
    end
`endif
endmodule

// File: tb/tb_adder4_cla_reg.sv
// Table-driven + exhaustive checks of adder4_cla_reg (WIDTH=4) alongside a random WIDTH=8 instance.
module tb_adder4_cla_reg;
    typedef struct {
        logic       r;
        logic [3:0] a;
        logic [3:0] b;
        logic       c0;
        logic [3:0] f;
        logic       c4;
        logic       ovf;
        string      nm;
    } vec_t;

    typedef struct {
        logic [3:0] f;
        logic       c4;
        logic       ovf;
        logic [7:0] f8;
        logic       c48;
        logic       ovf8;
        string      nm;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] A, B;
    logic       C0;
    logic       C4;
    logic [3:0] F;
    logic [7:0] A8, B8;
    logic       C08;
    logic       C48;
    logic [7:0] F8;
    logic       OVF, OVF8;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    vec_t tbl[6];

    adder4_cla_reg #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .C0(C0), .C4(C4), .F(F)
`ifdef ADDER_OVF_EN
        , .OVF(OVF)
`endif
    );

    adder4_cla_reg #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .A(A8), .B(B8), .C0(C08), .C4(C48), .F(F8)
`ifdef ADDER_OVF_EN
        , .OVF(OVF8)
`endif
    );

`ifndef ADDER_OVF_EN
    assign OVF  = 1'b0;
    assign OVF8 = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input string what, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s %s got=%h want=%h", nm, what, got, want);
        end
    endtask

    // Monitor: one result per edge following each driven cycle.
    always begin
        exp_t e;
        @(posedge clk);
        if (sb.size() != 0) begin
            #1;
            e = sb.pop_front();
            chk(e.nm, "F",   {4'b0, F},   {4'b0, e.f});
            chk(e.nm, "C4",  {7'b0, C4},  {7'b0, e.c4});
            chk(e.nm, "F8",  F8,          e.f8);
            chk(e.nm, "C48", {7'b0, C48}, {7'b0, e.c48});
`ifdef ADDER_OVF_EN
            chk(e.nm, "OVF",  {7'b0, OVF},  {7'b0, e.ovf});
            chk(e.nm, "OVF8", {7'b0, OVF8}, {7'b0, e.ovf8});
`endif
        end
    end

    // Drives one cycle; the WIDTH=8 instance gets random operands checked against a model.
    task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b, input logic c0,
                         input logic [3:0] ef, input logic ec4, input logic eovf, input string nm);
        exp_t e;
        logic [7:0] a8, b8;
        logic       c08;
        logic [8:0] s8;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        c08 = 1'($urandom);
        s8  = {1'b0, a8} + {1'b0, b8} + {8'b0, c08};
        @(negedge clk);
        rst = r; A = a; B = b; C0 = c0;
        A8 = a8; B8 = b8; C08 = c08;
        e.f = ef; e.c4 = ec4; e.ovf = eovf; e.nm = nm;
        e.f8   = r ? 8'h00 : s8[7:0];
        e.c48  = r ? 1'b0  : s8[8];
        e.ovf8 = r ? 1'b0  : ((a8[7] == b8[7]) && (s8[7] != a8[7]));
        sb.push_back(e);
    endtask

    task automatic drive_model(input logic r, input logic [3:0] a, input logic [3:0] b, input logic c0,
                               input string nm);
        logic [4:0] s;
        logic       ov;
        s  = {1'b0, a} + {1'b0, b} + {4'b0, c0};
        ov = (a[3] == b[3]) && (s[3] != a[3]);
        if (r) drive(r, a, b, c0, 4'h0, 1'b0, 1'b0, nm);
        else   drive(r, a, b, c0, s[3:0], s[4], ov, nm);
    endtask

    initial begin
        int n;
        rst = 1'b1; A = '0; B = '0; C0 = 1'b0;
        A8 = '0; B8 = '0; C08 = 1'b0;

        tbl[0] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, "reset"};
        tbl[1] = '{1'b0, 4'b1100, 4'b1011, 1'b0, 4'b0111, 1'b1, 1'b1, "v_c_1100_1011"};
        tbl[2] = '{1'b0, 4'b1011, 4'b0010, 1'b1, 4'b1110, 1'b0, 1'b0, "v_1011_0010_c"};
        tbl[3] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, "full_prop"};
        tbl[4] = '{1'b0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, "ovf_pos"};
        tbl[5] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "zero"};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++)
            drive(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].c0, tbl[i].f, tbl[i].c4, tbl[i].ovf, tbl[i].nm);

        // Reset mid-stream discards the in-flight sum; the next cycle resumes normally.
        drive(1'b0, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0, "pre_rst");
        drive(1'b1, 4'h5, 4'h5, 1'b1, 4'h0, 1'b0, 1'b0, "mid_rst");
        drive(1'b0, 4'h5, 4'h5, 1'b1, 4'hB, 1'b0, 1'b1, "post_rst");
        drive(1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, "all_ones_c");

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            drive_model(1'b0, v[3:0], v[7:4], v[8], "sweep");
        end

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
